// File: rtl/climate_sequencer.sv
// Heater/cooler/alarm sequencer: synchronized sensors drive an FSM that enforces
// a minimum on-time, a dead-time between actuator phases, and a latched fault alarm.
module climate_sequencer #(
  parameter int MIN_ON       = 4,
  parameter int DEAD_TIME    = 2,
  parameter int ALARM_CYCLES = 3,
  parameter int CNT_W        = 8
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       sensor1,
  input  logic       sensor2,
  input  logic       alarm_ack,
  output logic       heater,
  output logic       cooler,
  output logic       alarm,
  output logic [2:0] state_o
);

  localparam logic [2:0] IDLE  = 3'b000;
  localparam logic [2:0] HEAT  = 3'b001;
  localparam logic [2:0] COOL  = 3'b010;
  localparam logic [2:0] DEAD  = 3'b011;
  localparam logic [2:0] FAULT = 3'b100;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_ON_M1 = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] DEAD_M1   = CNT_W'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] ALARM_M1  = CNT_W'(ALARM_CYCLES - 1);

  logic [1:0]       sync1, sync2;
  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] timer, inv_cnt;
  logic             cold, hot, invalid, fault_hit;

  assign cold      = (sync2 == 2'b00);
  assign hot       = (sync2 == 2'b11);
  assign invalid   = (sync2 == 2'b01);
  assign fault_hit = invalid && (inv_cnt == ALARM_M1);
  assign state_o   = state;

  always_comb begin
    state_nxt = state;
    if (state != FAULT && fault_hit) begin
      state_nxt = FAULT;
    end else begin
      case (state)
        IDLE: begin
          if (enable && cold)     state_nxt = HEAT;
          else if (enable && hot) state_nxt = COOL;
        end
        HEAT:  if (timer >= MIN_ON_M1 && (!cold || !enable)) state_nxt = DEAD;
        COOL:  if (timer >= MIN_ON_M1 && (!hot || !enable))  state_nxt = DEAD;
        DEAD:  if (timer == DEAD_M1) state_nxt = IDLE;
        FAULT: if (alarm_ack && !invalid) state_nxt = DEAD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Synchronizers reset to the "ok" pattern so nothing heats straight out of reset.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 2'b10;
      sync2   <= 2'b10;
      state   <= IDLE;
      timer   <= '0;
      inv_cnt <= '0;
      heater  <= 1'b0;
      cooler  <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      sync1 <= {sensor1, sensor2};
      sync2 <= sync1;
      state <= state_nxt;
      if (state_nxt != state)  timer <= '0;
      else if (timer != CNT_MAX) timer <= timer + 1'b1;
      if (!invalid)              inv_cnt <= '0;
      else if (inv_cnt != CNT_MAX) inv_cnt <= inv_cnt + 1'b1;
      heater <= (state_nxt == HEAT);
      cooler <= (state_nxt == COOL);
      alarm  <= (state_nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_climate_sequencer.sv
// Scoreboard bench for climate_sequencer: a behavioural model predicts the outputs
// after each edge, a monitor compares them against the DUT one step behind.
module tb_climate_sequencer;

  localparam int MIN_ON       = 4;
  localparam int DEAD_TIME    = 2;
  localparam int ALARM_CYCLES = 3;
  localparam int SAT          = 255;

  logic       clk_2 = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0;
  logic       sensor1 = 1'b1;
  logic       sensor2 = 1'b0;
  logic       alarm_ack = 1'b0;
  logic       heater, cooler, alarm;
  logic [2:0] state_o;

  climate_sequencer #(
    .MIN_ON(MIN_ON), .DEAD_TIME(DEAD_TIME), .ALARM_CYCLES(ALARM_CYCLES), .CNT_W(8)
  ) dut (
    .clk_2(clk_2), .reset_n(reset_n), .enable(enable), .sensor1(sensor1),
    .sensor2(sensor2), .alarm_ack(alarm_ack), .heater(heater), .cooler(cooler),
    .alarm(alarm), .state_o(state_o)
  );

  always #5 clk_2 = ~clk_2;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  // Model: mode uses the documented state codes (0 idle,1 heat,2 cool,3 dead,4 fault).
  int         m_mode, m_age, m_bad;
  logic [1:0] m_s1, m_s2;

  function automatic logic [5:0] outs_of(input int mode);
    logic [5:0] v;
    v[5]   = (mode == 1);
    v[4]   = (mode == 2);
    v[3]   = (mode == 4);
    v[2:0] = 3'(mode);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_bad = 0; m_s1 = 2'b10; m_s2 = 2'b10;
  endtask

  task automatic model_clock(input logic en, input logic [1:0] s, input logic ack);
    int  nxt;
    logic fault;
    fault = (m_s2 == 2'b01) && (m_bad == ALARM_CYCLES - 1);
    nxt = m_mode;
    if (m_mode != 4 && fault) nxt = 4;
    else if (m_mode == 0) begin
      if (en && m_s2 == 2'b00) nxt = 1;
      else if (en && m_s2 == 2'b11) nxt = 2;
    end
    else if (m_mode == 1) begin
      if (m_age >= MIN_ON - 1 && (m_s2 != 2'b00 || !en)) nxt = 3;
    end
    else if (m_mode == 2) begin
      if (m_age >= MIN_ON - 1 && (m_s2 != 2'b11 || !en)) nxt = 3;
    end
    else if (m_mode == 3) begin
      if (m_age == DEAD_TIME - 1) nxt = 0;
    end
    else if (ack && m_s2 != 2'b01) nxt = 3;
    m_age  = (nxt != m_mode) ? 0 : ((m_age < SAT) ? m_age + 1 : SAT);
    m_bad  = (m_s2 == 2'b01) ? ((m_bad < SAT) ? m_bad + 1 : SAT) : 0;
    m_mode = nxt;
    m_s2   = m_s1;
    m_s1   = s;
  endtask

  // One clock of stimulus; a low rst is applied between edges and checked at once.
  task automatic step(input logic rst, input logic en, input logic [1:0] s, input logic ack);
    @(negedge clk_2);
    reset_n = rst; enable = en; {sensor1, sensor2} = s; alarm_ack = ack;
    if (!rst) begin
      #1;
      check("async_reset", {26'd0, heater, cooler, alarm, state_o}, 32'd0);
      model_reset();
    end else begin
      model_clock(en, s, ack);
    end
    exp_q.push_back(outs_of(m_mode));
  endtask

  initial begin : monitor
    logic [5:0] e;
    forever begin
      @(posedge clk_2);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", {26'd0, heater, cooler, alarm, state_o}, {26'd0, e});
        check("no_overlap", {31'd0, heater & cooler}, 32'd0);
      end
    end
  end

  initial begin : stim
    logic [1:0] pat;
    int hold;
    int r;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk_2);
    #1 check("reset_state", {26'd0, heater, cooler, alarm, state_o}, 32'd0);
    model_reset();

    // cold -> heat, then ok during heat: MIN_ON, dead-time, back to idle
    repeat (2) step(1, 1, 2'b00, 0);
    repeat (10) step(1, 1, 2'b10, 0);
    // cold then hot: heat, dead, idle, cool
    step(1, 1, 2'b00, 0);
    repeat (12) step(1, 1, 2'b11, 0);
    // asynchronous reset in the middle of cooling, then synchronizer latency
    repeat (2) step(0, 1, 2'b11, 0);
    repeat (8) step(1, 1, 2'b11, 0);
    // short invalid burst must not alarm
    repeat (8) step(1, 1, 2'b10, 0);
    repeat (2) step(1, 1, 2'b01, 0);
    repeat (6) step(1, 1, 2'b10, 0);
    // invalid during heat -> fault; ack ignored while still invalid
    repeat (4) step(1, 1, 2'b00, 0);
    repeat (4) step(1, 1, 2'b01, 0);
    repeat (3) step(1, 1, 2'b01, 1);
    repeat (6) step(1, 1, 2'b10, 1);
    repeat (6) step(1, 0, 2'b00, 0);

    hold = 0;
    pat = 2'b10;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 9);
        pat  = (r < 3) ? 2'b00 : (r < 6) ? 2'b10 : (r < 9) ? 2'b11 : 2'b01;
        hold = $urandom_range(1, 8);
      end
      hold--;
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0), pat,
           ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk_2);
    #2 check("drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/climate_sequencer.md
Name: climate_sequencer

Overview:
- Sequential controller for the lab's heater/cooler/alarm resource.
- Replaces direct combinational sensor-to-actuator decoding with a state machine.
- Guarantees a minimum actuator on-time and a dead-time between heater and cooler.
- Latches an alarm when the invalid sensor pattern persists. Sits between the board switches (sensors) and the LED/SEG outputs in top.

Parameters:
- MIN_ON, 4, cycles heater or cooler must stay on once entered (>=1).
- DEAD_TIME, 2, cycles both actuators are off between any actuator phase and the next decision (>=1).
- ALARM_CYCLES, 3, consecutive synchronized cycles of the invalid sensor pattern before entering fault (>=1).
- CNT_W, 8, width of phase timer and invalid counter; all thresholds must be < 2**CNT_W.

Ports:
- clk_2  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  control enable; when 0, no new actuator phase starts
- sensor1  in  1  temperature above low threshold
- sensor2  in  1  temperature above high threshold
- alarm_ack  in  1  operator acknowledge for fault
- heater  out  1  heater drive
- cooler  out  1  cooler drive
- alarm  out  1  alarm drive
- state_o  out  3  current state code, for LED display

Behaviour:
- Sensor encoding {sensor1,sensor2}:
  - 00 = cold
  - 10 = ok
  - 11 = hot
  - 01 = invalid
- Synchronizer: 2-flop synchronizer on sensor1 and sensor2. Both stages reset to ok (10), so no heating starts after reset. The FSM uses only the stage-2 values; enable and alarm_ack are used directly.
- States and codes: IDLE=000, HEAT=001, COOL=010, DEAD=011, FAULT=100.
- Outputs are registered, decoded from the state register: heater=(HEAT), cooler=(COOL), alarm=(FAULT), state_o=state. Heater and cooler are never both 1.
- Reset (async, reset_n=0): state=IDLE, timer=0, invalid counter=0, heater=cooler=alarm=0, state_o=000. Any state aborts immediately, with no clock required.
- Phase timer:
  - Cleared on every state change.
  - Otherwise increments each cycle and saturates at 2**CNT_W-1.
- Invalid counter:
  - Increments while the synced pattern is 01, saturating.
  - Cleared on any valid pattern.
  - fault_hit = (counter == ALARM_CYCLES-1) & synced pattern 01, i.e. the ALARM_CYCLES-th consecutive invalid cycle.
- Transitions, with priority top to bottom:
  - Any state except FAULT: fault_hit -> FAULT. This overrides MIN_ON and switches the actuator off on the next edge.
  - IDLE: enable & cold -> HEAT; enable & hot -> COOL; else stay.
  - HEAT: timer >= MIN_ON-1 & (!cold | !enable) -> DEAD; else stay. The heater is therefore high for at least MIN_ON cycles.
  - COOL: timer >= MIN_ON-1 & (!hot | !enable) -> DEAD; else stay.
  - DEAD: timer == DEAD_TIME-1 -> IDLE.
  - FAULT: alarm_ack & synced pattern valid -> DEAD. Ack while the pattern is still 01 is ignored and FAULT holds.
- Latency: an input change settling before edge k is visible in sync stage 2 after edge k+1; the state changes at edge k+2.
- No direct HEAT<->COOL path: the minimum off gap is DEAD_TIME cycles in DEAD plus 1 cycle in IDLE.
- Deasserting enable mid-phase does not cut MIN_ON short. Enable=0 in IDLE keeps the controller in IDLE regardless of sensors. Fault detection is independent of enable.

Test Plan:
- Reset release, enable=1, sensors 00 applied before edge 0 -> heater=1 after edge 2; state_o=001; cooler=alarm=0.
- In HEAT, sensors -> 10 one cycle after entry -> heater stays 1 for exactly 4 cycles, then state 011 for 2 cycles, then 000 with heater=0.
- Sensors 00 then held at 11 -> heater 4 cycles, DEAD 2 cycles, IDLE 1 cycle, then cooler=1; heater and cooler never overlap.
- Sensors 01 for 2 synced cycles then 10 -> no alarm. 01 for 3 synced cycles during HEAT (timer=1) -> FAULT, heater=0 and alarm=1 on the next edge.
- In FAULT: alarm_ack=1 with sensors 01 -> stays 100. alarm_ack=1 with sensors 10 -> DEAD for 2 cycles, then IDLE with alarm=0.
- reset_n=0 asynchronously mid-COOL (between edges) -> cooler=0 and state_o=000 immediately; after release with sensors 11 from reset, no actuator until 2 edges of synchronizer latency.
